// File: rtl/cycle_sequencer.sv
// T-state / M-cycle sequencer with instruction register and X/Y/Z one-hot decode.
// Latency: IR, step and count are registered (1 clock); decodes are zero-latency from IR. Backpressure: i_Stall holds T2, i_Clk_En freezes all state.
module cycle_sequencer (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Clk_En,
    input  logic       i_Stall,
    input  logic       i_IR_Fetch,
    input  logic [7:0] i_Data_Bus,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic [7:0] o_IR,
    output logic [3:0] o_X_Active,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic       o_M_Cycle_End,
    output logic       o_Overrun
);

    logic [3:0] step_q, step_d;
    logic [7:0] count_q, count_d;
    logic [7:0] ir_q, ir_d;
    logic       overrun_q, overrun_d;
    logic       m_end;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            step_q    <= 4'b0001;
            count_q   <= 8'h01;
            ir_q      <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            step_q    <= step_d;
            count_q   <= count_d;
            ir_q      <= ir_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_end = step_q[3] & i_Clk_En;

    always_comb begin
        step_d    = step_q;
        count_d   = count_q;
        ir_d      = ir_q;
        overrun_d = overrun_q;
        if (i_Clk_En) begin
            case (step_q)
                4'b0001: step_d = 4'b0010;
                4'b0010: step_d = i_Stall ? 4'b0010 : 4'b0100;
                4'b0100: step_d = 4'b1000;
                4'b1000: step_d = 4'b0001;
                default: step_d = step_q;
            endcase
        end
        // A fetch outranks saturation, so the last M-cycle may end exactly at M8.
        if (m_end) begin
            if (i_IR_Fetch) begin
                ir_d    = i_Data_Bus;
                count_d = 8'h01;
            end else if (count_q != 8'h80) begin
                count_d = {count_q[6:0], 1'b0};
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        o_Cycle_Step  = step_q;
        o_Cycle_Count = count_q;
        o_IR          = ir_q;
        o_Overrun     = overrun_q;
        o_M_Cycle_End = m_end;
        o_X_Active    = 4'b0001 << ir_q[7:6];
        o_Y           = 8'h01 << ir_q[5:3];
        o_Z           = 8'h01 << ir_q[2:0];
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed plus randomized bench for cycle_sequencer against an index-based reference model.
module tb_cycle_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b0;
    logic       i_Clk_En = 1'b0;
    logic       i_Stall = 1'b0;
    logic       i_IR_Fetch = 1'b0;
    logic [7:0] i_Data_Bus = 8'h00;
    logic [3:0] o_Cycle_Step;
    logic [7:0] o_Cycle_Count;
    logic [7:0] o_IR;
    logic [3:0] o_X_Active;
    logic [7:0] o_Y;
    logic [7:0] o_Z;
    logic       o_M_Cycle_End;
    logic       o_Overrun;

    cycle_sequencer dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Clk_En(i_Clk_En), .i_Stall(i_Stall),
        .i_IR_Fetch(i_IR_Fetch), .i_Data_Bus(i_Data_Bus),
        .o_Cycle_Step(o_Cycle_Step), .o_Cycle_Count(o_Cycle_Count), .o_IR(o_IR),
        .o_X_Active(o_X_Active), .o_Y(o_Y), .o_Z(o_Z),
        .o_M_Cycle_End(o_M_Cycle_End), .o_Overrun(o_Overrun)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: T-state index 0..3, M-cycle index 0..7, IR byte, sticky overrun.
    int         st;
    int         mc;
    logic [7:0] ir_m;
    logic       ovr_m;
    // -1: never fetch, -2: random fetch, n>=0: fetch when M-cycle index equals n
    int         fetch_bit = 0;

    task automatic model_reset();
        st = 0; mc = 0; ir_m = 8'h00; ovr_m = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("step",    8'(o_Cycle_Step), 8'(1 << st));
        chk("count",   o_Cycle_Count,    8'(1 << mc));
        chk("ir",      o_IR,             ir_m);
        chk("x",       8'(o_X_Active),   8'(1 << ir_m[7:6]));
        chk("y",       o_Y,              8'(1 << ir_m[5:3]));
        chk("z",       o_Z,              8'(1 << ir_m[2:0]));
        chk("overrun", 8'(o_Overrun),    8'(ovr_m));
    endtask

    task automatic cyc(input logic en, input logic stall);
        i_Clk_En = en;
        i_Stall  = stall;
        if (fetch_bit == -2) i_IR_Fetch = ($urandom % 3) == 0;
        else                 i_IR_Fetch = (fetch_bit >= 0) && (mc == fetch_bit);
        #1;
        chk("m_end", 8'(o_M_Cycle_End), 8'(st == 3 && en));
        @(posedge i_Clk);
        if (en) begin
            if (st == 3) begin
                if (i_IR_Fetch) begin
                    ir_m = i_Data_Bus;
                    mc   = 0;
                end else if (mc < 7) begin
                    mc = mc + 1;
                end else begin
                    ovr_m = 1'b1;
                end
                st = 0;
            end else if (!(st == 1 && stall)) begin
                st = st + 1;
            end
        end
        #1;
        check_all();
    endtask

    // Reset pulse placed strictly between clock edges; checked before the next edge.
    task automatic rst_pulse();
        #2 i_Reset = 1'b1;
        model_reset();
        #1 check_all();
        #1 i_Reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 i_Reset = 1'b1;
        #1 check_all();
        #1 i_Reset = 1'b0;

        // NOP stream, fetch on M1
        fetch_bit = 0; i_Data_Bus = 8'h00;
        repeat (12) cyc(1'b1, 1'b0);

        // Two-cycle ALU (HL) opcode then a one-cycle opcode
        i_Data_Bus = 8'h86;
        repeat (4) cyc(1'b1, 1'b0);
        chk("alu_x", 8'(o_X_Active), 8'h04);
        chk("alu_z", o_Z, 8'h40);
        fetch_bit = 1; i_Data_Bus = 8'h80;
        repeat (4) cyc(1'b1, 1'b0);
        chk("alu_m2", o_Cycle_Count, 8'h02);
        repeat (4) cyc(1'b1, 1'b0);
        chk("next_z", o_Z, 8'h01);
        fetch_bit = 0;
        repeat (4) cyc(1'b1, 1'b0);

        // Stall in T2 for 3 clocks, stall in T3 ignored, clock enable low
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1);
        chk("stall_hold", 8'(o_Cycle_Step), 8'h02);
        repeat (3) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("stall_t3", 8'(o_Cycle_Step), 8'h08);
        fetch_bit = -2; i_Data_Bus = 8'h3C;
        repeat (5) cyc(1'b0, 1'b1);
        fetch_bit = 0; i_Data_Bus = 8'h00;
        for (int i = 0; i < 8 && st != 0; i++) cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);

        // Overrun: 9 M-cycles with no fetch, then a fetch at saturation
        fetch_bit = -1;
        repeat (36) cyc(1'b1, 1'b0);
        chk("ovr_set", 8'(o_Overrun), 8'h01);
        chk("ovr_cnt", o_Cycle_Count, 8'h80);
        fetch_bit = 7; i_Data_Bus = 8'hC7;
        repeat (4) cyc(1'b1, 1'b0);
        chk("ovr_sticky", 8'(o_Overrun), 8'h01);
        chk("ovr_reload", o_Cycle_Count, 8'h01);

        // Fetch exactly at M8 does not overrun; reset during T3 of M3
        rst_pulse();
        fetch_bit = -1;
        repeat (28) cyc(1'b1, 1'b0);
        fetch_bit = 7; i_Data_Bus = 8'h12;
        repeat (4) cyc(1'b1, 1'b0);
        chk("sat_fetch_cnt", o_Cycle_Count, 8'h01);
        chk("sat_fetch_ovr", 8'(o_Overrun), 8'h00);
        fetch_bit = -1;
        repeat (10) cyc(1'b1, 1'b0);
        chk("m3_t3", o_Cycle_Count, 8'h04);
        rst_pulse();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            i_Data_Bus = 8'($urandom);
            fetch_bit  = ($urandom % 8 == 0) ? -1 : -2;
            cyc(($urandom % 4) != 0, 1'($urandom % 2));
            if ($urandom % 250 == 0) rst_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
